// File: rtl/dcache_assoc_if.sv
// CPU byte port and block memory port of the 2-way data cache, bundled as one interface.
interface dcache_assoc_if #(
  parameter int ADDR_W   = 8,
  parameter int OFFSET_W = 2,
  parameter int CNT_W    = 16
);
  localparam int BLK_W = 8 << OFFSET_W;

  logic                       read;
  logic                       write;
  logic [ADDR_W-1:0]          address;
  logic [7:0]                 writedata;
  logic                       flush;
  logic [7:0]                 readdata;
  logic                       busywait;
  logic                       mem_read;
  logic                       mem_write;
  logic [ADDR_W-OFFSET_W-1:0] mem_address;
  logic [BLK_W-1:0]           mem_writedata;
  logic [BLK_W-1:0]           mem_readdata;
  logic                       mem_busywait;
  logic [CNT_W-1:0]           hit_count;
  logic [CNT_W-1:0]           miss_count;

  modport slave (
    input  read, write, address, writedata, flush, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata,
           hit_count, miss_count
  );

  modport master (
    output read, write, address, writedata, flush, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata,
           hit_count, miss_count
  );
endinterface

// File: rtl/dcache_assoc.sv
// 2-way set-associative write-back, write-allocate data cache with LRU,
// whole-cache flush and saturating hit/miss counters.
module dcache_assoc #(
  parameter int ADDR_W   = 8,
  parameter int OFFSET_W = 2,
  parameter int INDEX_W  = 2,
  parameter int CNT_W    = 16
) (
  input logic           clk,
  input logic           rst_n,
  dcache_assoc_if.slave bus
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int SETS  = 1 << INDEX_W;
  localparam int BLK_W = 8 << OFFSET_W;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WRITEBACK = 3'd1;
  localparam logic [2:0] FETCH     = 3'd2;
  localparam logic [2:0] UPDATE    = 3'd3;
  localparam logic [2:0] FL_SCAN   = 3'd4;
  localparam logic [2:0] FL_WRITE  = 3'd5;

  logic [2:0]       state;
  logic             valid    [2][SETS];
  logic             dirty    [2][SETS];
  logic             lru      [SETS];
  logic [TAG_W-1:0] tag_mem  [2][SETS];
  logic [BLK_W-1:0] data_mem [2][SETS];
  logic [BLK_W-1:0] fill_q;
  logic [INDEX_W:0] fl_ptr;   // {set, way}: way toggles fastest
  logic             refilled;
  logic [CNT_W-1:0] hit_q;
  logic [CNT_W-1:0] miss_q;

  logic [TAG_W-1:0]    tag_in;
  logic [INDEX_W-1:0]  idx;
  logic [OFFSET_W-1:0] off;
  logic [1:0]          hit_w;
  logic                hit, hit_way, victim, req, done_hit;
  logic                fl_way, fl_last, fl_dirty;
  logic [INDEX_W-1:0]  fl_set;

  assign tag_in = bus.address[ADDR_W-1 -: TAG_W];
  assign idx    = bus.address[OFFSET_W +: INDEX_W];
  assign off    = bus.address[OFFSET_W-1:0];

  assign hit_w[0] = valid[0][idx] && (tag_mem[0][idx] == tag_in);
  assign hit_w[1] = valid[1][idx] && (tag_mem[1][idx] == tag_in);
  assign hit      = |hit_w;
  assign hit_way  = hit_w[1];
  // Fill an empty way before evicting; way 0 wins when both are empty.
  assign victim   = !valid[0][idx] ? 1'b0 : (!valid[1][idx] ? 1'b1 : lru[idx]);
  assign req      = bus.read | bus.write;
  assign done_hit = (state == IDLE) && req && hit;

  assign fl_way   = fl_ptr[0];
  assign fl_set   = fl_ptr[INDEX_W:1];
  assign fl_last  = &fl_ptr;
  assign fl_dirty = valid[fl_way][fl_set] && dirty[fl_way][fl_set];

  assign bus.busywait   = (state != IDLE) || (req && !hit) || (bus.flush && !req);
  assign bus.mem_read   = (state == FETCH);
  assign bus.mem_write  = (state == WRITEBACK) || (state == FL_WRITE);
  assign bus.hit_count  = hit_q;
  assign bus.miss_count = miss_q;

  // NOTE: every output in this block gets a default first, so no latch is inferred.
  always_comb begin
    bus.readdata      = '0;
    bus.mem_address   = '0;
    bus.mem_writedata = '0;
    if (done_hit && bus.read)
      bus.readdata = data_mem[hit_way][idx][{off, 3'b000} +: 8];
    case (state)
      WRITEBACK: begin
        bus.mem_address   = {tag_mem[victim][idx], idx};
        bus.mem_writedata = data_mem[victim][idx];
      end
      FETCH:     bus.mem_address = {tag_in, idx};
      FL_WRITE: begin
        bus.mem_address   = {tag_mem[fl_way][fl_set], fl_set};
        bus.mem_writedata = data_mem[fl_way][fl_set];
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fl_ptr   <= '0;
      refilled <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        lru[s]      <= 1'b0;
        valid[0][s] <= 1'b0;
        valid[1][s] <= 1'b0;
        dirty[0][s] <= 1'b0;
        dirty[1][s] <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (hit) begin
              lru[idx] <= ~hit_way;
              refilled <= 1'b0;
              if (bus.write) dirty[hit_way][idx] <= 1'b1;
              if (!refilled && hit_q != '1) hit_q <= hit_q + 1'b1;
            end else begin
              state <= (valid[victim][idx] && dirty[victim][idx]) ? WRITEBACK : FETCH;
              if (miss_q != '1) miss_q <= miss_q + 1'b1;
            end
          end else if (bus.flush) begin
            state <= FL_SCAN;
          end
        end
        WRITEBACK: if (!bus.mem_busywait) state <= FETCH;
        FETCH:     if (!bus.mem_busywait) state <= UPDATE;
        UPDATE: begin
          valid[victim][idx] <= 1'b1;
          dirty[victim][idx] <= 1'b0;
          refilled           <= 1'b1;
          state              <= IDLE;
        end
        FL_SCAN: begin
          if (fl_dirty) begin
            state <= FL_WRITE;
          end else begin
            fl_ptr <= fl_ptr + 1'b1;   // wraps to 0 after the last line
            if (fl_last) state <= IDLE;
          end
        end
        FL_WRITE: begin
          if (!bus.mem_busywait) begin
            dirty[fl_way][fl_set] <= 1'b0;
            fl_ptr                <= fl_ptr + 1'b1;
            state                 <= fl_last ? IDLE : FL_SCAN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: tag/data arrays carry no reset; valid bits alone decide whether they are meaningful.
  always_ff @(posedge clk) begin
    if (state == FETCH && !bus.mem_busywait) fill_q <= bus.mem_readdata;
    if (state == UPDATE) begin
      data_mem[victim][idx] <= fill_q;
      tag_mem[victim][idx]  <= tag_in;
    end
    if (done_hit && bus.write)
      data_mem[hit_way][idx][{off, 3'b000} +: 8] <= bus.writedata;
  end
endmodule

// File: tb/tb_dcache_assoc.sv
// Scoreboard bench for dcache_assoc: byte reference model, block memory with 5-cycle latency.
`timescale 1ns/1ps
module tb_dcache_assoc;
  localparam int LAT = 5;

  typedef struct { logic is_rd; logic [7:0] data; } rd_exp_t;
  typedef struct { logic wr; logic [5:0] addr; logic [31:0] data; } mem_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_assoc_if #(.ADDR_W(8), .OFFSET_W(2), .CNT_W(16)) bus_a ();
  dcache_assoc_if #(.ADDR_W(8), .OFFSET_W(2), .CNT_W(2))  bus_b ();

  dcache_assoc #(.ADDR_W(8), .OFFSET_W(2), .INDEX_W(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  dcache_assoc #(.ADDR_W(8), .OFFSET_W(2), .INDEX_W(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  int n_cmp = 0;
  int n_err = 0;
  int n_mem_rd = 0;
  int n_mem_wr = 0;
  int mcnt = 0;

  rd_exp_t   rd_q [$];
  mem_exp_t  mem_q [$];
  rd_exp_t   re;
  mem_exp_t  me;
  logic [7:0]  ref_b [256];
  logic [31:0] mem_a [64];

  // Block memory for dut_a: done on the LAT-th cycle of each request.
  always @(negedge clk) begin
    if (!rst_n || !(bus_a.mem_read || bus_a.mem_write)) begin
      mcnt = 0;
      bus_a.mem_busywait = 1'b1;
    end else begin
      mcnt = bus_a.mem_busywait ? mcnt + 1 : 1;
      bus_a.mem_readdata = mem_a[bus_a.mem_address];
      bus_a.mem_busywait = (mcnt < LAT);
      if (!bus_a.mem_busywait) begin
        n_cmp++;
        if (mem_q.size() == 0) begin
          n_err++;
          $display("FAIL mem_unexpected: got wr=%0b addr=%h, required no transfer",
                   bus_a.mem_write, bus_a.mem_address);
        end else begin
          me = mem_q.pop_front();
          if (bus_a.mem_write !== me.wr || bus_a.mem_read === me.wr ||
              bus_a.mem_address !== me.addr ||
              (me.wr && bus_a.mem_writedata !== me.data)) begin
            n_err++;
            $display("FAIL mem_transfer: got wr=%0b rd=%0b addr=%h data=%h, required wr=%0b addr=%h data=%h",
                     bus_a.mem_write, bus_a.mem_read, bus_a.mem_address, bus_a.mem_writedata,
                     me.wr, me.addr, me.data);
          end
        end
        if (bus_a.mem_write) begin
          mem_a[bus_a.mem_address] = bus_a.mem_writedata;
          n_mem_wr++;
        end else begin
          n_mem_rd++;
        end
      end
    end
  end

  // Load results of dut_a are compared in the cycle each access completes.
  always @(negedge clk) begin
    if (rst_n && (bus_a.read || bus_a.write) && !bus_a.busywait) begin
      if (rd_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL cpu_unexpected: got completion at addr %h, required none", bus_a.address);
      end else begin
        re = rd_q.pop_front();
        if (re.is_rd) begin
          n_cmp++;
          if (bus_a.readdata !== re.data) begin
            n_err++;
            $display("FAIL readdata@%h: got %h, required %h", bus_a.address, bus_a.readdata, re.data);
          end
        end
      end
    end
  end

  task automatic do_access(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                           output int stall);
    rd_exp_t e;
    e.is_rd = !wr;
    e.data  = wr ? 8'h00 : ref_b[addr];
    rd_q.push_back(e);
    if (wr) ref_b[addr] = wd;
    @(posedge clk); #1;
    bus_a.read = !wr; bus_a.write = wr; bus_a.address = addr; bus_a.writedata = wd;
    stall = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!bus_a.busywait) break;
      stall++;
    end
    @(posedge clk); #1;
    bus_a.read = 1'b0; bus_a.write = 1'b0;
  endtask

  task automatic do_flush(output int cyc, output logic bw_req);
    @(posedge clk); #1;
    bus_a.flush = 1'b1;
    @(negedge clk);
    bw_req = bus_a.busywait;
    @(posedge clk); #1;
    bus_a.flush = 1'b0;
    cyc = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!bus_a.busywait) break;
      cyc++;
    end
  endtask

  task automatic b_read(input logic [7:0] addr, output int stall, output logic [7:0] rd);
    @(posedge clk); #1;
    bus_b.read = 1'b1; bus_b.address = addr;
    stall = 0;
    rd = 8'h00;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!bus_b.busywait) break;
      stall++;
    end
    rd = bus_b.readdata;
    @(posedge clk); #1;
    bus_b.read = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] obs [9];
    string nm [9];
    bus_a.read = 0; bus_a.write = 0; bus_a.flush = 0; bus_a.address = '0; bus_a.writedata = '0;
    bus_b.read = 0; bus_b.write = 0; bus_b.flush = 0; bus_b.address = '0; bus_b.writedata = '0;
    bus_b.mem_busywait = 1'b0;
    bus_b.mem_readdata = 32'h4433_2211;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    obs[0] = 32'(bus_a.busywait);      nm[0] = "busywait";
    obs[1] = 32'(bus_a.mem_read);      nm[1] = "mem_read";
    obs[2] = 32'(bus_a.mem_write);     nm[2] = "mem_write";
    obs[3] = 32'(bus_a.mem_address);   nm[3] = "mem_address";
    obs[4] = bus_a.mem_writedata;      nm[4] = "mem_writedata";
    obs[5] = 32'(bus_a.readdata);      nm[5] = "readdata";
    obs[6] = 32'(bus_a.hit_count);     nm[6] = "hit_count";
    obs[7] = 32'(bus_a.miss_count);    nm[7] = "miss_count";
    obs[8] = 32'(bus_b.hit_count);     nm[8] = "b_hit_count";
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (obs[i] !== 32'h0) begin
        n_err++;
        $display("FAIL reset_%s: got %h, required 0", nm[i], obs[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_read_miss_hit();
    int st, tr;
    mem_q.push_back('{1'b0, 6'h00, 32'h0});
    do_access(1'b0, 8'h00, 8'h00, st);
    n_cmp++; if (st !== 7) begin n_err++; $display("FAIL clean_miss_stall: got %0d, required 7", st); end
    n_cmp++; if (bus_a.miss_count !== 16'd1) begin n_err++; $display("FAIL miss_count_1: got %0d, required 1", bus_a.miss_count); end
    n_cmp++; if (bus_a.hit_count !== 16'd0) begin n_err++; $display("FAIL refill_not_hit: got %0d, required 0", bus_a.hit_count); end
    tr = n_mem_rd + n_mem_wr;
    do_access(1'b0, 8'h01, 8'h00, st);
    n_cmp++; if (st !== 0) begin n_err++; $display("FAIL hit_stall: got %0d, required 0", st); end
    n_cmp++; if (bus_a.hit_count !== 16'd1) begin n_err++; $display("FAIL hit_count_1: got %0d, required 1", bus_a.hit_count); end
    n_cmp++; if (n_mem_rd + n_mem_wr !== tr) begin n_err++; $display("FAIL hit_traffic: got %0d transfers, required %0d", n_mem_rd + n_mem_wr, tr); end
  endtask

  task automatic test_write_hit();
    int st, s2, tr;
    tr = n_mem_rd + n_mem_wr;
    do_access(1'b1, 8'h02, 8'h5A, st);
    do_access(1'b0, 8'h02, 8'h00, s2);
    n_cmp++; if (st !== 0 || s2 !== 0) begin n_err++; $display("FAIL write_hit_stall: got %0d/%0d, required 0/0", st, s2); end
    n_cmp++; if (bus_a.hit_count !== 16'd3) begin n_err++; $display("FAIL hit_count_3: got %0d, required 3", bus_a.hit_count); end
    n_cmp++; if (n_mem_rd + n_mem_wr !== tr) begin n_err++; $display("FAIL write_traffic: got %0d transfers, required %0d", n_mem_rd + n_mem_wr, tr); end
  endtask

  task automatic test_conflict();
    int st;
    mem_q.push_back('{1'b0, 6'h04, 32'h0});
    do_access(1'b0, 8'h10, 8'h00, st);
    n_cmp++; if (st !== 7) begin n_err++; $display("FAIL way1_fill_stall: got %0d, required 7", st); end
    mem_q.push_back('{1'b1, 6'h00, 32'hDD5A_BBAA});
    mem_q.push_back('{1'b0, 6'h08, 32'h0});
    do_access(1'b0, 8'h20, 8'h00, st);
    n_cmp++; if (st !== 12) begin n_err++; $display("FAIL dirty_miss_stall: got %0d, required 12", st); end
    n_cmp++; if (bus_a.miss_count !== 16'd3) begin n_err++; $display("FAIL miss_count_3: got %0d, required 3", bus_a.miss_count); end
    do_access(1'b0, 8'h11, 8'h00, st);
    n_cmp++; if (st !== 0) begin n_err++; $display("FAIL lru_kept_way1: got %0d, required 0", st); end
  endtask

  task automatic test_flush();
    int st, cyc, wr0;
    logic bw;
    mem_q.push_back('{1'b0, 6'h01, 32'h0});
    do_access(1'b0, 8'h04, 8'h00, st);
    mem_q.push_back('{1'b0, 6'h05, 32'h0});
    do_access(1'b0, 8'h14, 8'h00, st);
    do_access(1'b1, 8'h15, 8'h77, st);
    mem_q.push_back('{1'b1, 6'h05, {ref_b[8'h17], ref_b[8'h16], ref_b[8'h15], ref_b[8'h14]}});
    wr0 = n_mem_wr;
    do_flush(cyc, bw);
    n_cmp++; if (bw !== 1'b1) begin n_err++; $display("FAIL flush_req_busy: got %b, required 1", bw); end
    n_cmp++; if (cyc !== 13) begin n_err++; $display("FAIL dirty_flush_cycles: got %0d, required 13", cyc); end
    n_cmp++; if (n_mem_wr - wr0 !== 1) begin n_err++; $display("FAIL flush_writes: got %0d, required 1", n_mem_wr - wr0); end
    wr0 = n_mem_wr;
    do_flush(cyc, bw);
    n_cmp++; if (cyc !== 8) begin n_err++; $display("FAIL clean_flush_cycles: got %0d, required 8", cyc); end
    n_cmp++; if (n_mem_wr - wr0 !== 0) begin n_err++; $display("FAIL reflush_writes: got %0d, required 0", n_mem_wr - wr0); end
    do_access(1'b0, 8'h15, 8'h00, st);
    n_cmp++; if (st !== 0) begin n_err++; $display("FAIL flushed_line_valid: got %0d stall, required 0", st); end
  endtask

  task automatic test_reset_in_fetch();
    int st;
    logic seen;
    seen = 1'b0;
    @(posedge clk); #1;
    bus_a.read = 1'b1; bus_a.address = 8'h30;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_a.mem_read) begin seen = 1'b1; break; end
    end
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL fetch_start: got no mem_read, required mem_read"); end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    bus_a.read = 1'b0;
    #1;
    n_cmp++; if (bus_a.mem_read !== 1'b0) begin n_err++; $display("FAIL rst_mem_read: got %b, required 0", bus_a.mem_read); end
    n_cmp++; if (bus_a.busywait !== 1'b0) begin n_err++; $display("FAIL rst_busywait: got %b, required 0", bus_a.busywait); end
    n_cmp++; if (bus_a.miss_count !== 16'd0) begin n_err++; $display("FAIL rst_miss_count: got %0d, required 0", bus_a.miss_count); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mem_q.push_back('{1'b0, 6'h0C, 32'h0});
    do_access(1'b0, 8'h30, 8'h00, st);
    n_cmp++; if (st !== 7) begin n_err++; $display("FAIL rst_remiss_stall: got %0d, required 7", st); end
    n_cmp++; if (bus_a.miss_count !== 16'd1) begin n_err++; $display("FAIL rst_remiss_count: got %0d, required 1", bus_a.miss_count); end
  endtask

  task automatic test_saturate();
    int st;
    logic [7:0] rd;
    logic [1:0] exp_hits;
    b_read(8'h00, st, rd);
    n_cmp++; if (st !== 3 || rd !== 8'h11) begin n_err++; $display("FAIL b_fill: got stall %0d data %h, required 3 / 11", st, rd); end
    for (int i = 1; i <= 7; i++) begin
      b_read(8'h01, st, rd);
      exp_hits = (i > 3) ? 2'd3 : 2'(i);
      n_cmp++;
      if (st !== 0 || rd !== 8'h22 || bus_b.hit_count !== exp_hits) begin
        n_err++;
        $display("FAIL b_hit%0d: got stall %0d data %h count %0d, required 0 / 22 / %0d",
                 i, st, rd, bus_b.hit_count, exp_hits);
      end
    end
    n_cmp++; if (bus_b.miss_count !== 2'd1) begin n_err++; $display("FAIL b_miss_count: got %0d, required 1", bus_b.miss_count); end
  endtask

  task automatic test_drain();
    n_cmp++;
    if (rd_q.size() !== 0 || mem_q.size() !== 0) begin
      n_err++;
      $display("FAIL drain: got %0d cpu / %0d mem pending, required 0 / 0", rd_q.size(), mem_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_b[i] = 8'(i) ^ 8'h3C;
    ref_b[0] = 8'hAA; ref_b[1] = 8'hBB; ref_b[2] = 8'hCC; ref_b[3] = 8'hDD;
    for (int j = 0; j < 64; j++)
      mem_a[j] = {ref_b[4*j+3], ref_b[4*j+2], ref_b[4*j+1], ref_b[4*j]};
    test_reset();
    test_read_miss_hit();
    test_write_hit();
    test_conflict();
    test_flush();
    test_reset_in_fetch();
    test_saturate();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
